// File: rtl/regfile_wb_bypass.sv
// 32-entry LEGv8 register file with a decoded write port and two combinational
// read ports that forward the same-cycle writeback result; X31 always reads zero.
module regfile_wb_bypass #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic [31:0]      enable;
    logic [WIDTH-1:0] regs [32];
    logic             bypass1;
    logic             bypass2;

    // One-hot decoder; the zero row is never enabled so it stays at its reset value.
    always_comb begin
        enable                = '0;
        enable[WriteRegister] = RegWrite;
        enable[ZERO_IDX]      = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (enable[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    assign bypass1 = RegWrite && (WriteRegister == ReadRegister1) && (WriteRegister != ZERO_IDX);
    assign bypass2 = RegWrite && (WriteRegister == ReadRegister2) && (WriteRegister != ZERO_IDX);

    // Reset and XZR take priority over the forwarding path on both ports.
    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (reset || (ReadRegister1 == ZERO_IDX)) begin
            ReadData1 = '0;
        end else if (bypass1) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadRegister2];
        if (reset || (ReadRegister2 == ZERO_IDX)) begin
            ReadData2 = '0;
        end else if (bypass2) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_regfile_wb_bypass.sv
// Directed bench for regfile_wb_bypass: vector table for write/read/bypass
// behaviour plus hand sequences for asynchronous reset and the reset/write race.
module tb_regfile_wb_bypass;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  write_reg;
        logic [63:0] write_data;
        logic [4:0]  read_reg1;
        logic [4:0]  read_reg2;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } vec_t;

    vec_t vecs[$];

    regfile_wb_bypass #(.WIDTH(64), .ZERO_REG(31)) dut (
        .clk(clk),
        .reset(reset),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drive one vector just after the falling edge so it is sampled by the next rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        RegWrite      = v.reg_write;
        WriteRegister = v.write_reg;
        WriteData     = v.write_data;
        ReadRegister1 = v.read_reg1;
        ReadRegister2 = v.read_reg2;
        #1;
    endtask

    function automatic vec_t mk(input logic we, input int wr, input logic [63:0] wd,
                                input int r1, input int r2,
                                input logic [63:0] e1, input logic [63:0] e2);
        vec_t v;
        v.reg_write  = we;
        v.write_reg  = 5'(wr);
        v.write_data = wd;
        v.read_reg1  = 5'(r1);
        v.read_reg2  = 5'(r2);
        v.exp1       = e1;
        v.exp2       = e2;
        return v;
    endfunction

    initial begin
        logic [63:0] e1;
        logic [63:0] e2;

        // Write X0..X30 while port 1 watches the bypass and port 2 watches XZR.
        for (int i = 0; i < 31; i++) begin
            vecs.push_back(mk(1'b1, i, 64'h1000 + 64'(i), i, 31, 64'h1000 + 64'(i), 64'h0));
        end
        for (int i = 0; i < 32; i++) begin
            e1 = (i == 31) ? 64'h0 : 64'h1000 + 64'(i);
            e2 = (i == 0)  ? 64'h0 : 64'h1000 + 64'(31 - i);
            vecs.push_back(mk(1'b0, 0, 64'h0, i, 31 - i, e1, e2));
        end
        vecs.push_back(mk(1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 30, 64'h0, 64'h101E));
        vecs.push_back(mk(1'b0, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 64'h0, 64'h0));
        vecs.push_back(mk(1'b1, 7, 64'h11, 6, 8, 64'h1006, 64'h1008));
        vecs.push_back(mk(1'b0, 7, 64'h22, 7, 7, 64'h11, 64'h11));
        vecs.push_back(mk(1'b1, 7, 64'h22, 7, 7, 64'h22, 64'h22));
        vecs.push_back(mk(1'b0, 0, 64'h0, 7, 7, 64'h22, 64'h22));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1'b0, 3, 64'hABC, 3, 2, 64'h1003, 64'h1002));
        end
        vecs.push_back(mk(1'b1, 3, 64'h333, 2, 4, 64'h1002, 64'h1004));
        vecs.push_back(mk(1'b0, 0, 64'h0, 2, 4, 64'h1002, 64'h1004));
        vecs.push_back(mk(1'b0, 0, 64'h0, 3, 5, 64'h333, 64'h1005));

        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd5;
        WriteData     = 64'h1234;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd0;
        #2;
        checkOutput("reset rd1 bypass suppressed", ReadData1, 64'h0);
        checkOutput("reset rd2", ReadData2, 64'h0);
        @(posedge clk);
        #1;
        checkOutput("reset held across edge", ReadData1, 64'h0);
        @(negedge clk);
        reset    = 1'b0;
        RegWrite = 1'b0;
        #1;
        checkOutput("after reset X5", ReadData1, 64'h0);

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("vec %0d rd1", k), ReadData1, vecs[k].exp1);
            checkOutput($sformatf("vec %0d rd2", k), ReadData2, vecs[k].exp2);
        end

        // Asynchronous reset pulse between edges.
        applyStimulus(mk(1'b1, 5, 64'hDEAD_BEEF_0000_0001, 6, 0, 64'h1006, 64'h1000));
        applyStimulus(mk(1'b0, 0, 64'h0, 5, 9, 64'hDEAD_BEEF_0000_0001, 64'h1009));
        checkOutput("X5 written", ReadData1, 64'hDEAD_BEEF_0000_0001);
        reset = 1'b1;
        #1;
        checkOutput("async reset X5", ReadData1, 64'h0);
        checkOutput("async reset X9", ReadData2, 64'h0);
        reset = 1'b0;
        #1;
        checkOutput("X5 after reset drop", ReadData1, 64'h0);
        checkOutput("X9 after reset drop", ReadData2, 64'h0);

        // Reset asserted on the same edge that carries a write to X9.
        applyStimulus(mk(1'b1, 9, 64'h55, 10, 10, 64'h0, 64'h0));
        @(posedge clk);
        reset = 1'b1;
        applyStimulus(mk(1'b0, 0, 64'h0, 9, 9, 64'h0, 64'h0));
        reset = 1'b0;
        #1;
        checkOutput("race X9", ReadData1, 64'h0);
        applyStimulus(mk(1'b1, 9, 64'h66, 8, 8, 64'h0, 64'h0));
        applyStimulus(mk(1'b0, 0, 64'h0, 9, 8, 64'h66, 64'h0));
        checkOutput("post race X9 write", ReadData1, 64'h66);
        checkOutput("post race X8 cleared", ReadData2, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
